// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit in front of a word-wide internal RAM
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   req_valid/req_ready      request handshake; ready only while idle
//   req_addr/req_we/
//   req_funct3/req_wdata     byte address, store flag, access type, store data
//   mem_enable/mem_addr/
//   mem_oplen/mem_we/
//   mem_wdata                one-cycle RAM command (always word sized)
//   mem_valid/mem_rdata      RAM completion and read data
//   rsp_valid/rsp_data/
//   rsp_err                  one-cycle response pulse with load data and error flag
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_oplen,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    RESP
  } state_t;

  localparam logic [31:0] GPIO_ADDR = 32'hFFFF_FFFF;
  // Last wait cycle index; mem_valid on this cycle still counts as success.
  localparam logic [3:0]  TO_LAST   = 4'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic        gpio_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  logic        req_gpio;
  logic        req_bad;
  logic        req_rmw;
  logic        accept;
  logic        in_wait;
  logic        mem_timeout;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // ---------------------------------------------------------------------------
  // Request decode: legality, alignment and access path
  // ---------------------------------------------------------------------------
  assign req_gpio = (req_addr == GPIO_ADDR);

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = !req_gpio && req_addr[0];
      3'b010:  req_bad = !req_gpio && (req_addr[1:0] != 2'b00);
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we || (!req_gpio && req_addr[0]);
      default: req_bad = 1'b1;
    endcase
  end

  // Sub-word stores to RAM must read the word first; GPIO is always a plain word.
  assign req_rmw  = req_we && !req_gpio && (req_funct3 != 3'b010);
  assign accept   = (state == IDLE) && req_valid;
  assign in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
  assign mem_timeout = in_wait && !mem_valid && (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // Load extraction and store merge
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
  end

  assign sel_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = mem_rdata;
    if (!gpio_q) begin
      case (f3_q)
        3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
        3'b100:  load_data = {24'd0, sel_byte};
        3'b101:  load_data = {16'd0, sel_half};
        default: load_data = mem_rdata;
      endcase
    end
  end

  always_comb begin
    merge_data = mem_rdata;
    if (f3_q[0] == 1'b0) begin
      case (addr_q[1:0])
        2'd0: merge_data[7:0]   = wdata_q[7:0];
        2'd1: merge_data[15:8]  = wdata_q[7:0];
        2'd2: merge_data[23:16] = wdata_q[7:0];
        2'd3: merge_data[31:24] = wdata_q[7:0];
        default: merge_data = mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merge_data[31:16] = wdata_q[15:0];
    end else begin
      merge_data[15:0] = wdata_q[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_next = RESP;
          end else if (req_we && !req_rmw) begin
            state_next = WR_ISSUE;
          end else begin
            state_next = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (mem_valid) begin
          state_next = we_q ? WR_ISSUE : RESP;
        end else if (mem_timeout) begin
          state_next = RESP;
        end
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT: begin
        if (mem_valid || mem_timeout) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= 32'd0;
      gpio_q     <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      wdata_q    <= 32'd0;
      cnt_q      <= 4'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        gpio_q     <= req_gpio;
        we_q       <= req_we;
        f3_q       <= req_funct3;
        wdata_q    <= req_wdata;
        rsp_data_q <= 32'd0;
        rsp_err_q  <= req_bad;
      end

      // Counter restarts at zero on every entry into a wait state.
      if (in_wait && !mem_valid && !mem_timeout) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= 4'd0;
      end

      if (state == RD_WAIT && mem_valid) begin
        if (we_q) begin
          wdata_q <= merge_data;
        end else begin
          rsp_data_q <= load_data;
        end
      end

      if (mem_timeout) begin
        rsp_err_q  <= 1'b1;
        rsp_data_q <= 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; everything is forced quiet while reset is held
  // ---------------------------------------------------------------------------
  assign req_ready  = rst && (state == IDLE);
  assign mem_enable = rst && ((state == RD_ISSUE) || (state == WR_ISSUE));
  assign mem_we     = rst && (state == WR_ISSUE);
  assign mem_addr   = !mem_enable ? 32'd0 :
                      gpio_q      ? addr_q : {addr_q[31:2], 2'b00};
  assign mem_oplen  = mem_enable ? 2'b10 : 2'b00;
  assign mem_wdata  = mem_we ? wdata_q : 32'd0;
  assign rsp_valid  = rst && (state == RESP);
  assign rsp_data   = rsp_valid ? rsp_data_q : 32'd0;
  assign rsp_err    = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic [1:0]  mem_oplen;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_oplen  (mem_oplen),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  // RAM model: 256 words plus a GPIO register at 0xFFFFFFFF
  logic [31:0] ram [0:255];
  logic [31:0] gpio_reg     = 32'd0;
  logic        model_valid  = 1'b0;
  logic [31:0] model_rdata  = 32'd0;
  logic        pend         = 1'b0;
  int          cd           = 0;
  int          acc_cnt      = 0;
  int          wr_cnt       = 0;
  int          oplen_bad    = 0;
  logic [31:0] last_rd_addr = 32'd0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  logic        ram_stall;
  int          ram_delay;
  logic        force_valid;
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_val;

  assign mem_valid = model_valid | force_valid;
  assign mem_rdata = model_rdata;

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (ld_en) ram[ld_idx] <= ld_val;
    if (mem_enable) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_oplen != 2'b10) oplen_bad <= oplen_bad + 1;
      if (mem_we) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
        if (mem_addr == 32'hFFFF_FFFF) gpio_reg <= mem_wdata;
        else ram[mem_addr[9:2]] <= mem_wdata;
      end else begin
        last_rd_addr <= mem_addr;
      end
      model_rdata <= (mem_addr == 32'hFFFF_FFFF) ? gpio_reg : ram[mem_addr[9:2]];
      if (!ram_stall) begin
        if (ram_delay == 0) begin
          model_valid <= 1'b1;
        end else begin
          pend <= 1'b1;
          cd   <= ram_delay;
        end
      end
    end else if (pend) begin
      if (cd == 1) begin
        model_valid <= 1'b1;
        pend        <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = idx;
    ld_val = val;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  // Issues one request and returns the number of clock edges from the accept
  // edge to the edge that samples rsp_valid (99 when no response arrives).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] data,
                        output logic err, output int n_acc);
    int acc0;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    acc0       = acc_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 99;
    data = 32'hDEAD_BEEF;
    err  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat  = i;
        data = rsp_data;
        err  = rsp_err;
        break;
      end
    end
    n_acc = acc_cnt - acc0;
  endtask

  int          lat;
  logic [31:0] data;
  logic        err;
  int          n_acc;
  logic        seen;

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 32'd0;
    req_we      = 1'b0;
    req_funct3  = 3'd0;
    req_wdata   = 32'd0;
    ram_stall   = 1'b0;
    ram_delay   = 0;
    force_valid = 1'b0;
    ld_en       = 1'b0;
    ld_idx      = 8'd0;
    ld_val      = 32'd0;

    preload(8'd64, 32'h80FF_1234);
    preload(8'd65, 32'h9ABC_0000);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_oplen", 32'(mem_oplen), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // LB 0x103 of 0x80FF1234
    do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, lat, data, err, n_acc);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_data", data, 32'hFFFF_FF80);
    check("lb_err", 32'(err), 32'd0);
    check("lb_acc", 32'(n_acc), 32'd1);
    check("lb_addr", last_rd_addr, 32'h0000_0100);

    do_req(1'b0, 3'b100, 32'h0000_0103, 32'd0, lat, data, err, n_acc);
    check("lbu_lat", 32'(lat), 32'd3);
    check("lbu_data", data, 32'h0000_0080);

    // SB 0x102 read-modify-write
    preload(8'd64, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00AB, lat, data, err, n_acc);
    check("sb_lat", 32'(lat), 32'd5);
    check("sb_acc", 32'(n_acc), 32'd2);
    check("sb_rd_addr", last_rd_addr, 32'h0000_0100);
    check("sb_wr_addr", last_wr_addr, 32'h0000_0100);
    check("sb_wr_data", last_wr_data, 32'h11AB_3344);
    check("sb_err", 32'(err), 32'd0);
    check("sb_data", data, 32'd0);

    do_req(1'b0, 3'b001, 32'h0000_0102, 32'd0, lat, data, err, n_acc);
    check("lh_hi_data", data, 32'h0000_11AB);
    do_req(1'b0, 3'b001, 32'h0000_0106, 32'd0, lat, data, err, n_acc);
    check("lh_sext_data", data, 32'hFFFF_9ABC);
    do_req(1'b0, 3'b101, 32'h0000_0106, 32'd0, lat, data, err, n_acc);
    check("lhu_data", data, 32'h0000_9ABC);

    // Misaligned and illegal requests
    do_req(1'b0, 3'b010, 32'h0000_0102, 32'd0, lat, data, err, n_acc);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", 32'(err), 32'd1);
    check("lw_mis_data", data, 32'd0);
    check("lw_mis_acc", 32'(n_acc), 32'd0);
    do_req(1'b0, 3'b011, 32'h0000_0100, 32'd0, lat, data, err, n_acc);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_data", data, 32'd0);
    check("ill_acc", 32'(n_acc), 32'd0);
    do_req(1'b1, 3'b001, 32'h0000_0101, 32'h1234, lat, data, err, n_acc);
    check("sh_mis_err", 32'(err), 32'd1);
    check("sh_mis_acc", 32'(n_acc), 32'd0);

    // GPIO word store then load
    do_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_0005, lat, data, err, n_acc);
    check("gpio_sw_lat", 32'(lat), 32'd3);
    check("gpio_sw_acc", 32'(n_acc), 32'd1);
    check("gpio_sw_addr", last_wr_addr, 32'hFFFF_FFFF);
    check("gpio_sw_err", 32'(err), 32'd0);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd0, lat, data, err, n_acc);
    check("gpio_lw_data", data, 32'h0000_0005);

    // Plain word store takes a single write access
    do_req(1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, lat, data, err, n_acc);
    check("sw_lat", 32'(lat), 32'd3);
    check("sw_acc", 32'(n_acc), 32'd1);
    check("sw_wr_data", last_wr_data, 32'hCAFE_F00D);

    // mem_valid on the last allowed wait cycle is still a success
    ram_delay = 14;
    do_req(1'b0, 3'b010, 32'h0000_0104, 32'd0, lat, data, err, n_acc);
    check("late_lat", 32'(lat), 32'd17);
    check("late_err", 32'(err), 32'd0);
    check("late_data", data, 32'hCAFE_F00D);
    ram_delay = 0;

    // Timeout with mem_valid held low
    ram_stall = 1'b1;
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, lat, data, err, n_acc);
    check("to_lat", 32'(lat), 32'd17);
    check("to_err", 32'(err), 32'd1);
    check("to_data", data, 32'd0);
    check("to_acc", 32'(n_acc), 32'd1);
    @(negedge clk);
    check("to_ready_after", 32'(req_ready), 32'd1);

    // Reset while in RD_WAIT, then a stale mem_valid
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    ram_stall = 1'b0;
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, lat, data, err, n_acc);
    check("after_rst_lat", 32'(lat), 32'd3);
    check("after_rst_data", data, 32'h11AB_3344);
    check("after_rst_err", 32'(err), 32'd0);

    check("oplen_word", 32'(oplen_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
